// File: rtl/eb_ser.sv
// eb_ser: elastic W-to-W/N width down-converter, LSB slice first; optional i_last via EB_SER_LAST_EN
module eb_ser #(
  parameter int W = 32,
  parameter int N = 4,
  localparam int OW = W / N,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [W-1:0]  t_dat,
  input  logic          t_req,
  output logic          t_ack,
  output logic [OW-1:0] i_dat,
  output logic          i_req,
  input  logic          i_ack,
`ifdef EB_SER_LAST_EN
  output logic          i_last,
`endif
  output logic [CW-1:0] cnt
);
  typedef enum logic {EMPTY, BUSY} state_t;
  state_t state, state_nx;
  logic [W-1:0] dat, dat_nx;
  logic [CW-1:0] cnt_nx;
  logic full, last, load;
  assign full = state == BUSY;
  assign last = cnt == CW'(N - 1);
  assign t_ack = ~full | (last & i_ack);
  assign load = t_req & t_ack;
  assign i_req = full;
  assign i_dat = dat[cnt*OW +: OW];
`ifdef EB_SER_LAST_EN
  assign i_last = full & last;
`endif
  // next word/beat/state: a load takes priority, otherwise step or retire on an acked beat
  always_comb begin
    state_nx = state;
    dat_nx = dat;
    cnt_nx = cnt;
    if (load) begin
      state_nx = BUSY;
      dat_nx = t_dat;
      cnt_nx = '0;
    end else if (full & i_ack) begin
      state_nx = last ? EMPTY : BUSY;
      cnt_nx = last ? '0 : cnt + CW'(1);
    end
  end
  // state registers; reset discards any partial word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      dat <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      dat <= dat_nx;
      cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_eb_ser.sv
// tb_eb_ser: directed and random checks of eb_ser against a beat-queue reference model
module tb_eb_ser;
  localparam int W = 32;
  localparam int N = 4;
  localparam int OW = W / N;
  localparam int CW = $clog2(N);
  logic clk = 0;
  logic reset_n;
  logic [W-1:0] t_dat;
  logic t_req, t_ack, i_req, i_ack;
  logic [OW-1:0] i_dat;
  logic [CW-1:0] cnt;
`ifdef EB_SER_LAST_EN
  logic i_last;
`endif
  int total = 0;
  int bad = 0;
  bit acc = 0;
  logic [OW-1:0] q[$];

  eb_ser #(.W(W), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .t_dat(t_dat), .t_req(t_req), .t_ack(t_ack),
    .i_dat(i_dat), .i_req(i_req), .i_ack(i_ack),
`ifdef EB_SER_LAST_EN
    .i_last(i_last),
`endif
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_i_req", 32'(i_req), 0);
    chk("rst_t_ack", 32'(t_ack), 1);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_i_dat", 32'(i_dat), 0);
`ifdef EB_SER_LAST_EN
    chk("rst_i_last", 32'(i_last), 0);
`endif
  endtask

  // queue holds the beats of the word in flight still to be emitted
  task automatic cycle();
    bit xi, xo;
    int sz;
    @(negedge clk);
    sz = q.size();
    if (!reset_n) chk_reset();
    else begin
      chk("i_req", 32'(i_req), 32'(sz != 0));
      chk("cnt", 32'(cnt), sz != 0 ? 32'(N - sz) : 0);
      if (sz != 0) chk("i_dat", 32'(i_dat), 32'(q[0]));
      chk("t_ack", 32'(t_ack), 32'(sz == 0 || (sz == 1 && i_ack)));
`ifdef EB_SER_LAST_EN
      chk("i_last", 32'(i_last), 32'(sz == 1));
`endif
    end
    xi = reset_n && t_req && (sz == 0 || (sz == 1 && i_ack));
    xo = reset_n && sz != 0 && i_ack;
    @(posedge clk);
    if (xo) void'(q.pop_front());
    if (xi) for (int b = 0; b < N; b++) q.push_back(t_dat[b*OW +: OW]);
    acc = xi;
    #1;
  endtask

  initial begin
    reset_n = 0; t_req = 0; t_dat = 0; i_ack = 0;
    #1 chk_reset();
    repeat (2) cycle();
    reset_n = 1;
    // single word
    t_req = 1; t_dat = 32'hDDCCBBAA; i_ack = 1;
    cycle();
    t_req = 0;
    repeat (6) cycle();
    // streaming two words with no bubble
    t_req = 1; t_dat = 32'h03020100;
    cycle();
    t_dat = 32'h07060504;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (acc) break;
    end
    chk("stream_accept", 32'(acc), 1);
    t_req = 0;
    repeat (6) cycle();
    // backpressure at cnt=2
    t_req = 1; t_dat = 32'hDDCCBBAA;
    cycle();
    t_req = 0;
    repeat (2) cycle();
    i_ack = 0;
    repeat (5) cycle();
    chk("bp_cnt", 32'(cnt), 2);
    chk("bp_dat", 32'(i_dat), 32'hCC);
    i_ack = 1;
    repeat (4) cycle();
    // input stall then late request
    t_req = 1; t_dat = 32'h11223344;
    cycle();
    t_req = 0;
    repeat (7) cycle();
    t_req = 1; t_dat = 32'h55667788;
    cycle();
    chk("late_accept", 32'(acc), 1);
    t_req = 0;
    repeat (5) cycle();
    // reset mid-word at cnt=1
    t_req = 1; t_dat = 32'h99AABBCC;
    cycle();
    t_req = 0;
    cycle();
    chk("pre_rst_cnt", 32'(cnt), 1);
    reset_n = 0;
    #1 chk_reset();
    q.delete();
    cycle();
    reset_n = 1;
    t_req = 1; t_dat = 32'hCAFEF00D;
    cycle();
    t_req = 0;
    repeat (5) cycle();
    // random traffic with held requests
    for (int i = 0; i < 400; i++) begin
      if (!t_req || acc) begin
        t_req = 1'($urandom_range(0, 1));
        t_dat = $urandom;
      end
      i_ack = $urandom_range(0, 3) != 0;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
